// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one byte-masked load/store request, holds it
// for a fixed LATENCY, then presents a response until the core takes it.
// One request in flight at a time; the word array is not cleared by reset.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            rerr_q, rerr_d;

   logic [31:0]     mem_q [DEPTH];

   // Decode of the incoming request; the full addr[31:2] takes part in the
   // range check so high address bits can never alias onto a legal word.
   logic            in_err;
   logic [AW-1:0]   in_idx;

   // Request used on the edge entering RESP: live inputs when LATENCY==1
   // (acceptance and response share one edge), else the latched copy.
   logic            src_we;
   logic [AW-1:0]   src_idx;
   logic [31:0]     src_wdata;
   logic [3:0]      src_be;
   logic            src_err;

   logic            enter_resp;
   logic            mem_wr;

   assign in_err = (req_addr[1:0] != 2'b00) | (req_addr[31:2] >= 30'(DEPTH));
   assign in_idx = req_addr[AW+1:2];

   // Select between live request and latched request for the response edge.
   always_comb begin
      if (state_q == S_IDLE) begin
         src_we    = req_we;
         src_idx   = in_idx;
         src_wdata = req_wdata;
         src_be    = req_be;
         src_err   = in_err;
      end else begin
         src_we    = we_q;
         src_idx   = idx_q;
         src_wdata = wdata_q;
         src_be    = be_q;
         src_err   = err_q;
      end
   end

   // Next-state logic, handshake outputs and response-data capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      rerr_d     = rerr_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      enter_resp = 1'b0;
      mem_wr     = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = reset;
            if (req_valid && reset) begin
               we_d    = req_we;
               idx_d   = in_idx;
               wdata_d = req_wdata;
               be_d    = req_be;
               err_d   = in_err;
               cnt_d   = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (enter_resp) begin
         rerr_d = src_err;
         if (!src_we && !src_err) begin
            rdata_d = mem_q[src_idx];
         end else begin
            rdata_d = 32'h0;
         end
         // A reset edge drops the pending request, so its write never lands.
         mem_wr = src_we && !src_err && reset;
      end
   end

   // Control and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   // Byte-masked store into the word array; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (src_be[i]) begin
               mem_q[src_idx][8*i +: 8] <= src_wdata[8*i +: 8];
            end
         end
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance carries most of the
// sequence, a LATENCY=1 instance checks the single-edge response path.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;

   logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic [3:0]  req_be;

   logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1;
   logic [31:0] req_addr1, req_wdata1, resp_rdata1;
   logic [3:0]  req_be1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid1),
      .req_ready  (req_ready1),
      .req_we     (req_we1),
      .req_addr   (req_addr1),
      .req_wdata  (req_wdata1),
      .req_be     (req_be1),
      .resp_valid (resp_valid1),
      .resp_ready (resp_ready1),
      .resp_rdata (resp_rdata1),
      .resp_err   (resp_err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction with resp_ready held high from the start.
   // lat counts edges from the acceptance edge (counted as 1) to resp_valid.
   task automatic txn(input bit u1, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic er, output int lat);
      if (!u1) begin
         req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
         resp_ready = 1'b1;
         chk("ready_before_req", 32'(req_ready), 32'd1);
      end else begin
         req_valid1 = 1'b1; req_we1 = we; req_addr1 = addr; req_wdata1 = wd; req_be1 = be;
         resp_ready1 = 1'b1;
         chk("ready_before_req_l1", 32'(req_ready1), 32'd1);
      end
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_valid1 = 1'b0;
      lat = 1;
      while (!(u1 ? resp_valid1 : resp_valid) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = u1 ? resp_rdata1 : resp_rdata;
      er = u1 ? resp_err1 : resp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      reset = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
      resp_ready = 1'b0;
      req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = 32'h0; req_wdata1 = 32'h0; req_be1 = 4'h0;
      resp_ready1 = 1'b0;

      // Reset held low for two edges
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);

      // Full-word store, then load back
      txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      chk("st10_lat", 32'(lat), 32'd2);
      chk("st10_rdata", rd, 32'h0);
      chk("st10_err", 32'(er), 32'd0);
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      chk("ld10_rdata", rd, 32'hDEADBEEF);
      chk("ld10_err", 32'(er), 32'd0);

      // Byte-lane merge: byte 1 replaced
      txn(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
      chk("st10_b1_err", 32'(er), 32'd0);
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      chk("ld10_merged", rd, 32'hDEADAAEF);

      // Error cases
      txn(1'b0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
      chk("ld12_err", 32'(er), 32'd1);
      chk("ld12_rdata", rd, 32'h0);
      txn(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, rd, er, lat);
      chk("ld_depth_err", 32'(er), 32'd1);
      chk("ld_depth_rdata", rd, 32'h0);
      txn(1'b0, 1'b0, 32'h80000010, 32'h0, 4'hF, rd, er, lat);
      chk("ld_hibits_err", 32'(er), 32'd1);
      txn(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      chk("st13_err", 32'(er), 32'd1);
      chk("st13_rdata", rd, 32'h0);
      txn(1'b0, 1'b1, 32'h10, 32'h11111111, 4'h0, rd, er, lat);
      chk("st_be0_err", 32'(er), 32'd0);
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      chk("ld10_untouched", rd, 32'hDEADAAEF);

      // Highest legal word
      txn(1'b0, 1'b1, 32'hFC, 32'h12345678, 4'hF, rd, er, lat);
      chk("stFC_err", 32'(er), 32'd0);
      txn(1'b0, 1'b0, 32'hFC, 32'h0, 4'hF, rd, er, lat);
      chk("ldFC_rdata", rd, 32'h12345678);
      chk("ldFC_err", 32'(er), 32'd0);

      // Back-pressure in RESP with spurious requests
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd2);
      for (int k = 0; k < 5; k++) begin
         req_valid = (k % 2 == 0); req_we = 1'b1; req_addr = 32'h10;
         req_wdata = 32'h0; req_be = 4'hF;
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         chk("bp_resp_valid", 32'(resp_valid), 32'd1);
         chk("bp_rdata", resp_rdata, 32'hDEADAAEF);
         chk("bp_err", 32'(resp_err), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(resp_valid), 32'd0);
      chk("bp_release_ready", 32'(req_ready), 32'd1);
      txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      chk("bp_ignored_stores", rd, 32'hDEADAAEF);

      // Reset during WAIT drops the pending store
      txn(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, er, lat);
      chk("st20_err", 32'(er), 32'd0);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55555555; req_be = 4'hF;
      @(posedge clk); #1;
      chk("wait_resp_valid", 32'(resp_valid), 32'd0);
      req_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready_after", 32'(req_ready), 32'd1);
      txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
      chk("ld20_unchanged", rd, 32'h0BADF00D);

      // LATENCY=1 instance
      txn(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, rd, er, lat);
      chk("l1_st_lat", 32'(lat), 32'd1);
      chk("l1_st_err", 32'(er), 32'd0);
      txn(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
      chk("l1_ld_lat", 32'(lat), 32'd1);
      chk("l1_ld_rdata", rd, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
